// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - frame load / filter / drain / readout sequencer for the binary median filter
// Optional macro BORDER_COPY_EN: loaded pixels are mirrored into dst so uncovered border pixels equal the input.
module frame_scheduler #(
  parameter int IMAGE_WIDTH  = 240,
  parameter int IMAGE_HEIGHT = 180,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loadValid,
  input  logic        loadData,
  output logic        loadReady,
  output logic        filterStart,
  input  logic        filterReady,
  input  logic        filterDone,
  input  logic [7:0]  filterX,
  input  logic [7:0]  filterY,
  input  logic        medianWe,
  input  logic [7:0]  medianX,
  input  logic [7:0]  medianY,
  input  logic        medianData,
  output logic [15:0] srcAddr,
  output logic        srcWe,
  output logic        srcWdata,
  output logic [15:0] dstAddr,
  output logic        dstWe,
  output logic        dstWdata,
  input  logic        dstRdata,
  output logic        outValid,
  output logic        outData,
  input  logic        outReady,
  output logic        busy,
  output logic [7:0]  frameCount
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START   = 3'd1,
    S_FILTER  = 3'd2,
    S_DRAIN   = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam logic [15:0] WIDTH16    = 16'(IMAGE_WIDTH);
  localparam logic [15:0] LAST_ADDR  = 16'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] pixel_count;
  logic [15:0] drain_count;
  logic [15:0] read_addr;
  logic [15:0] filter_addr;
  logic        rd_pending;
  logic        out_valid_q;
  logic        out_data_q;
  logic [7:0]  frame_count_q;

  logic load_fire, load_last, out_fire, out_last, drain_last;

  function automatic logic [15:0] linear(input logic [7:0] x, input logic [7:0] y);
    return {8'd0, y} * WIDTH16 + {8'd0, x};
  endfunction

  assign load_fire  = (state == S_LOAD) && loadValid;
  assign load_last  = load_fire && (pixel_count == LAST_ADDR);
  assign out_fire   = (state == S_READOUT) && out_valid_q && outReady;
  assign out_last   = out_fire && (read_addr == LAST_ADDR);
  assign drain_last = (state == S_DRAIN) && (drain_count == DRAIN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:    if (load_last)   state_next = S_START;
      S_START:   if (filterReady) state_next = S_FILTER;
      S_FILTER:  if (filterDone)  state_next = S_DRAIN;
      S_DRAIN:   if (drain_last)  state_next = S_READOUT;
      S_READOUT: if (out_last)    state_next = S_LOAD;
      default:                    state_next = S_LOAD;
    endcase
  end

  // rd_pending marks the cycle in which dst read data for read_addr is on dstRdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_count   <= '0;
      drain_count   <= '0;
      read_addr     <= '0;
      filter_addr   <= '0;
      rd_pending    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (load_fire)
        pixel_count <= load_last ? 16'd0 : pixel_count + 16'd1;

      if (state == S_FILTER)
        filter_addr <= linear(filterX, filterY);

      if (state == S_FILTER && filterDone) drain_count <= '0;
      else if (state == S_DRAIN)           drain_count <= drain_count + 16'd1;

      if (drain_last) begin
        read_addr   <= '0;
        rd_pending  <= 1'b0;
        out_valid_q <= 1'b0;
      end

      if (state == S_READOUT) begin
        if (out_fire) begin
          out_valid_q <= 1'b0;
          if (out_last) begin
            frame_count_q <= frame_count_q + 8'd1;
            rd_pending    <= 1'b0;
          end else begin
            read_addr  <= read_addr + 16'd1;
            rd_pending <= 1'b1;
          end
        end else if (rd_pending) begin
          out_data_q  <= dstRdata;
          out_valid_q <= 1'b1;
          rd_pending  <= 1'b0;
        end else if (!out_valid_q) begin
          rd_pending <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    loadReady   = (state == S_LOAD);
    filterStart = (state == S_START) && filterReady;
    srcAddr     = '0;
    srcWe       = 1'b0;
    srcWdata    = 1'b0;
    dstAddr     = '0;
    dstWe       = 1'b0;
    dstWdata    = 1'b0;
    case (state)
      S_LOAD: begin
        srcAddr  = pixel_count;
        srcWe    = loadValid;
        srcWdata = loadData;
`ifdef BORDER_COPY_EN
        dstAddr  = pixel_count;
        dstWe    = loadValid;
        dstWdata = loadData;
`endif
      end
      S_FILTER, S_DRAIN: begin
        srcAddr  = filter_addr;
        dstAddr  = linear(medianX, medianY);
        dstWe    = medianWe;
        dstWdata = medianData;
      end
      // On a handshake the next read is issued in the same cycle to sustain two cycles per pixel.
      S_READOUT: dstAddr = out_fire ? read_addr + 16'd1 : read_addr;
      default: ;
    endcase
  end

  assign outValid   = out_valid_q;
  assign outData    = out_data_q;
  assign busy       = !((state == S_LOAD) && (pixel_count == 16'd0));
  assign frameCount = frame_count_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - directed table-driven bench for frame_scheduler with memory and filter models
module tb_frame_scheduler;
  localparam int W = 8;
  localparam int H = 6;
  localparam int D = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        loadValid = 1'b0, loadData = 1'b0, loadReady;
  logic        filterStart, filterReady = 1'b0, filterDone = 1'b0;
  logic [7:0]  filterX = '0, filterY = '0, medianX = '0, medianY = '0;
  logic        medianWe = 1'b0, medianData = 1'b0;
  logic [15:0] srcAddr, dstAddr;
  logic        srcWe, srcWdata, dstWe, dstWdata;
  logic        dstRdata;
  logic        outValid, outData, outReady = 1'b0, busy;
  logic [7:0]  frameCount;

  frame_scheduler #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .loadValid(loadValid), .loadData(loadData), .loadReady(loadReady),
    .filterStart(filterStart), .filterReady(filterReady), .filterDone(filterDone),
    .filterX(filterX), .filterY(filterY),
    .medianWe(medianWe), .medianX(medianX), .medianY(medianY), .medianData(medianData),
    .srcAddr(srcAddr), .srcWe(srcWe), .srcWdata(srcWdata),
    .dstAddr(dstAddr), .dstWe(dstWe), .dstWdata(dstWdata), .dstRdata(dstRdata),
    .outValid(outValid), .outData(outData), .outReady(outReady),
    .busy(busy), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   src_wr_count = 0;
  int   src_addr_err = 0;
  int   start_count = 0;
  logic src_mem [N];
  logic dst_mem [N];
  logic in_pix  [N];
  logic [3:0] rp;

  typedef struct {
    logic [7:0]  fx, fy, mx, my;
    logic        mwe, md;
    logic [15:0] exp_dst;
    logic        exp_we;
    logic [15:0] exp_src;
  } vec_t;
  vec_t vecs [6];

  // Memory models: src write port, dst write port plus 1-cycle synchronous read.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) dst_mem[i] <= 1'b0;
    end else begin
      if (srcWe) begin
        if (srcAddr != 16'(src_wr_count % N)) src_addr_err <= src_addr_err + 1;
        if (srcAddr < 16'(N)) src_mem[srcAddr] <= srcWdata;
        src_wr_count <= src_wr_count + 1;
      end
      if (dstWe && dstAddr < 16'(N)) dst_mem[dstAddr] <= dstWdata;
    end
    if (filterStart) start_count <= start_count + 1;
    dstRdata <= (dstAddr < 16'(N)) ? dst_mem[dstAddr] : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_pix(input int a);
    int x, y;
    x = a % W;
    y = a / W;
    if (x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2) return !in_pix[a];
`ifdef BORDER_COPY_EN
    return in_pix[a];
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_frame();
    for (int i = 0; i < N; i++) begin
      loadValid = 1'b1;
      loadData  = in_pix[i];
      if (i == 10) begin
        #1;
        check("busy_mid_load", busy, 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_filter();
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        medianX    = 8'(x);
        medianY    = 8'(y);
        medianData = !in_pix[y * W + x];
        medianWe   = 1'b1;
        filterDone = (y == H - 2) && (x == W - 2);
        if (filterDone) begin
          #1;
          check("last_write_we", dstWe, 1);
          check("last_write_addr", dstAddr, 16'((H - 2) * W + W - 2));
        end
        @(negedge clk);
      end
    end
    medianWe   = 1'b0;
    filterDone = 1'b0;
  endtask

  task automatic readout(input int npix);
    int   cyc = 0;
    int   idx = 0;
    logic held_v = 1'b0;
    logic held_d = 1'b0;
    while (idx < npix && cyc < 400) begin
      outReady = rp[cyc % 4];
      #1;
      if (held_v) begin
        check("stall_hold_valid", outValid, 1);
        check("stall_hold_data", outData, held_d);
      end
      if (outValid && outReady) begin
        check($sformatf("pixel_%0d", idx), outData, exp_pix(idx));
        idx++;
        held_v = 1'b0;
      end else begin
        held_v = outValid;
        held_d = outData;
      end
      @(negedge clk);
      cyc++;
    end
    outReady = 1'b0;
    if (idx < npix) check("readout_timeout", idx, npix);
  endtask

  initial begin
    int c;
    rp = 4'b1001;
    for (int i = 0; i < N; i++) in_pix[i] = ((i * 5 + 1) % 3 == 1);
    vecs[0] = '{8'd3, 8'd2, 8'd3, 8'd2, 1'b1, 1'b1, 16'd19, 1'b1, 16'd19};
    vecs[1] = '{8'd0, 8'd0, 8'd1, 8'd1, 1'b1, 1'b1, 16'd9,  1'b1, 16'd0};
    vecs[2] = '{8'd7, 8'd5, 8'd6, 8'd4, 1'b1, 1'b0, 16'd38, 1'b1, 16'd47};
    vecs[3] = '{8'd1, 8'd4, 8'd0, 8'd0, 1'b0, 1'b1, 16'd0,  1'b0, 16'd33};
    vecs[4] = '{8'd6, 8'd1, 8'd7, 8'd5, 1'b0, 1'b1, 16'd47, 1'b0, 16'd14};
    vecs[5] = '{8'd2, 8'd3, 8'd5, 8'd3, 1'b1, 1'b1, 16'd29, 1'b1, 16'd26};

    repeat (3) @(negedge clk);
    check("rst_out_valid", outValid, 0);
    check("rst_out_data", outData, 0);
    check("rst_filter_start", filterStart, 0);
    check("rst_src_we", srcWe, 0);
    check("rst_dst_we", dstWe, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frameCount, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_load_ready", loadReady, 1);

    medianWe = 1'b1; medianX = 8'd3; medianY = 8'd2; medianData = 1'b1;
    #1;
    check("load_median_ignored", dstWe, 0);
    medianWe = 1'b0;
    @(negedge clk);

    load_frame();
    check("start_after_last_ready", loadReady, 0);
    check("start_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("start_hold_no_pulse", filterStart, 0);
      @(negedge clk);
    end
    loadValid = 1'b0;
    filterReady = 1'b1;
    #1;
    check("start_pulse", filterStart, 1);
    @(negedge clk);
    filterReady = 1'b0;
    #1;
    check("start_pulse_ends", filterStart, 0);
    check("src_write_count", src_wr_count, N);
    check("src_write_order", src_addr_err, 0);
    check("start_pulse_count", start_count, 1);
    for (int i = 0; i < N; i++) if (src_mem[i] !== in_pix[i]) check($sformatf("src_%0d", i), src_mem[i], in_pix[i]);

    for (int i = 0; i < 6; i++) begin
      filterX = vecs[i].fx; filterY = vecs[i].fy;
      medianX = vecs[i].mx; medianY = vecs[i].my;
      medianWe = vecs[i].mwe; medianData = vecs[i].md;
      #1;
      check($sformatf("vec%0d_dst_addr", i), dstAddr, vecs[i].exp_dst);
      check($sformatf("vec%0d_dst_we", i), dstWe, vecs[i].exp_we);
      check($sformatf("vec%0d_dst_data", i), dstWdata, vecs[i].md);
      @(negedge clk);
      check($sformatf("vec%0d_src_addr", i), srcAddr, vecs[i].exp_src);
      check($sformatf("vec%0d_src_we", i), srcWe, 0);
    end
    medianWe = 1'b0;

    run_filter();
    medianX = 8'd1; medianY = 8'd1; medianData = !in_pix[W + 1]; medianWe = 1'b1;
    #1;
    check("drain_passthru_we", dstWe, 1);
    @(negedge clk);
    medianWe = 1'b0;
    check("drain_no_out", outValid, 0);
    check("drain_busy", busy, 1);

    readout(N);
    check("frame_count_1", frameCount, 1);
    check("back_to_load", loadReady, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", outValid, 0);

    load_frame();
    loadValid = 1'b0;
    filterReady = 1'b1;
    @(negedge clk);
    filterReady = 1'b0;
    run_filter();
    readout(20);
    c = 0;
    while (!outValid && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("pre_reset_valid", outValid, 1);
    reset = 1'b0;
    #1;
    check("abort_out_valid", outValid, 0);
    check("abort_frame_count", frameCount, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_load_ready", loadReady, 1);
    check("post_reset_busy", busy, 0);
    loadValid = 1'b1;
    loadData = 1'b1;
    #1;
    check("post_reset_src_addr", srcAddr, 0);
    loadValid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
